// File: rtl/mac_sequencer.sv
// mac_sequencer: on a start pulse, streams LEN operand/coefficient pairs from
// two memories sharing a read address, multiply-accumulates them, offers the
// sum on a valid/ready port, then pulses done for one cycle.
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int LEN    = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inner_rst,
  input  logic              inner_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Last address of a run; the counter parks here instead of wrapping.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                pv;   // read issued last cycle -> memory data valid now
  logic [ACC_W-1:0]    acc;
  logic [2*DATA_W-1:0] prod;
  logic                start_run;

  // Full-width unsigned product; operands widened explicitly so no bits drop.
  assign prod = {{DATA_W{1'b0}}, rd_data} * {{DATA_W{1'b0}}, coef_data};

  assign start_run = (state == IDLE) && inner_start;
  assign rd_addr   = cnt;
  assign out_data  = acc;

  // Control FSM; rd_en/out_valid/done are registered alongside the state so
  // they always reflect the state and never depend combinationally on inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else if (inner_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inner_start) begin
            state <= FETCH;
            cnt   <= '0;
            rd_en <= 1'b1;
          end
        end
        FETCH: begin
          // The read at LAST_ADDR is issued this cycle; stop fetching after it.
          if (cnt == LAST_ADDR) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Final product is absorbed by the datapath on this edge.
          state     <= OUTPUT;
          out_valid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: read-valid pipeline bit and accumulator. A start clears both so
  // a run never sees leftovers; inner_rst drops any in-flight product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv  <= 1'b0;
      acc <= '0;
    end else if (inner_rst) begin
      pv  <= 1'b0;
      acc <= '0;
    end else if (start_run) begin
      pv  <= 1'b0;
      acc <= '0;
    end else begin
      pv <= rd_en;
      // Sum wraps modulo 2**ACC_W by construction.
      if (pv) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a 20-bit and a 16-bit accumulator instance run in
// lockstep on the same memories; results are compared against a sum-of-products
// model over the memory contents and against the documented cycle map.
module tb_mac_sequencer;
  localparam int DATA_W = 8;
  localparam int LEN    = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, inner_rst, inner_start, out_ready;
  logic [DATA_W-1:0] rd_data, coef_data;
  logic              rd_en, out_valid, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [19:0]       out_data;
  logic              rd_en16, out_valid16, done16;
  logic [ADDR_W-1:0] rd_addr16;
  logic [15:0]       out_data16;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem_a [LEN];
  logic [DATA_W-1:0] mem_c [LEN];

  mac_sequencer #(.DATA_W(8), .LEN(LEN), .ADDR_W(4), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .inner_rst(inner_rst), .inner_start(inner_start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done));

  mac_sequencer #(.DATA_W(8), .LEN(LEN), .ADDR_W(4), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .inner_rst(inner_rst), .inner_start(inner_start),
    .rd_en(rd_en16), .rd_addr(rd_addr16), .rd_data(rd_data), .coef_data(coef_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .done(done16));

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data   <= mem_a[rd_addr];
      coef_data <= mem_c[rd_addr];
    end
  end

  // Reference: sum of products over the whole memory, reduced mod 2**w.
  function automatic longint model(input int w);
    longint s = 0;
    for (int i = 0; i < LEN; i++) s += longint'(mem_a[i]) * longint'(mem_c[i]);
    return s % (longint'(1) << w);
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < LEN; i++) begin
      case (mode)
        0: begin mem_a[i] = 8'd1; mem_c[i] = 8'd2; end
        1: begin mem_a[i] = 8'(i); mem_c[i] = 8'(i); end
        2: begin mem_a[i] = 8'd255; mem_c[i] = 8'd255; end
        default: begin mem_a[i] = 8'($urandom); mem_c[i] = 8'($urandom); end
      endcase
    end
  endtask

  // Observations of one run (cycle numbers count from 1 = first cycle after start edge).
  int          r_done_cyc, r_valid_cyc, r_rd_first, r_rd_cnt;
  bit          r_addr_ok, r_stable, r_lockstep;
  logic [19:0] r_data;
  logic [15:0] r_data16;

  // Starts a run, holds out_ready low for bp valid cycles, optionally pulses
  // inner_start again at cycle ign_cyc; returns at the negedge of the done cycle.
  task automatic run_once(input int bp, input int ign_cyc);
    int v;
    v = 0;
    r_done_cyc = -1; r_valid_cyc = -1; r_rd_first = -1; r_rd_cnt = 0;
    r_addr_ok = 1; r_stable = 1; r_lockstep = 1; r_data = '0; r_data16 = '0;
    out_ready = (bp == 0);
    @(negedge clk); inner_start = 1'b1;
    @(negedge clk); inner_start = 1'b0;
    for (int cyc = 1; cyc <= LEN + bp + 40 && r_done_cyc < 0; cyc++) begin
      if (rd_en) begin
        if (r_rd_first < 0) r_rd_first = cyc;
        if (rd_addr !== ADDR_W'(r_rd_cnt)) r_addr_ok = 0;
        r_rd_cnt++;
      end
      if (rd_en16 !== rd_en || rd_addr16 !== rd_addr || out_valid16 !== out_valid || done16 !== done)
        r_lockstep = 0;
      if (out_valid) begin
        v++;
        if (v == 1) begin
          r_valid_cyc = cyc; r_data = out_data; r_data16 = out_data16;
        end else if (out_data !== r_data || out_data16 !== r_data16) r_stable = 0;
        out_ready = (v > bp);
      end
      if (done) r_done_cyc = cyc;
      inner_start = (cyc == ign_cyc);
      if (r_done_cyc < 0) @(negedge clk);
    end
    inner_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; inner_rst = 1'b0; inner_start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rd_en, rd_addr, out_valid, out_data, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got en=%b addr=%0d vld=%b data=%0d done=%b want all 0",
               rd_en, rd_addr, out_valid, out_data, done);
    end
    vectors++;
    if ({rd_en16, rd_addr16, out_valid16, out_data16, done16} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs16 got data=%0d vld=%b want all 0", out_data16, out_valid16);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    fill(0);
    run_once(0, -1);
    vectors++;
    if (r_data !== 20'd32) begin miscompares++; $display("FAIL basic_data got %0d want 32", r_data); end
    vectors++;
    if (r_rd_first != 1 || r_rd_cnt != LEN || !r_addr_ok) begin
      miscompares++;
      $display("FAIL basic_reads got first=%0d cnt=%0d seq_ok=%0d want 1 16 1", r_rd_first, r_rd_cnt, r_addr_ok);
    end
    vectors++;
    if (r_valid_cyc != LEN + 2) begin miscompares++; $display("FAIL basic_valid_cycle got %0d want %0d", r_valid_cyc, LEN + 2); end
    vectors++;
    if (r_done_cyc != LEN + 3) begin miscompares++; $display("FAIL basic_done_cycle got %0d want %0d", r_done_cyc, LEN + 3); end
    vectors++;
    if (!r_lockstep) begin miscompares++; $display("FAIL basic_lockstep got 0 want 1"); end
  endtask

  task automatic test_ramp;
    fill(1);
    run_once(0, -1);
    vectors++;
    if (r_data !== 20'd1240) begin miscompares++; $display("FAIL ramp_data got %0d want 1240", r_data); end
    vectors++;
    if (r_data16 !== 16'd1240) begin miscompares++; $display("FAIL ramp_data16 got %0d want 1240", r_data16); end
  endtask

  task automatic test_max;
    fill(2);
    run_once(0, -1);
    vectors++;
    if (r_data !== 20'(model(20))) begin miscompares++; $display("FAIL max_data got %0d want %0d", r_data, model(20)); end
    vectors++;
    if (r_data16 !== 16'd57360) begin miscompares++; $display("FAIL max_data16_wrap got %0d want 57360", r_data16); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      int bp;
      fill(3);
      bp = int'($urandom_range(0, 3));
      run_once(bp, -1);
      vectors++;
      if (r_data !== 20'(model(20)) || r_data16 !== 16'(model(16))) begin
        miscompares++;
        $display("FAIL random_data[%0d] got %0d/%0d want %0d/%0d", k, r_data, r_data16, model(20), model(16));
      end
      vectors++;
      if (r_done_cyc != LEN + 3 + bp || !r_stable) begin
        miscompares++;
        $display("FAIL random_timing[%0d] got done=%0d stable=%0d want %0d 1", k, r_done_cyc, r_stable, LEN + 3 + bp);
      end
    end
  endtask

  task automatic test_backpressure;
    fill(3);
    run_once(5, -1);
    vectors++;
    if (!r_stable || r_valid_cyc != LEN + 2) begin
      miscompares++;
      $display("FAIL bp_hold got stable=%0d valid_cyc=%0d want 1 %0d", r_stable, r_valid_cyc, LEN + 2);
    end
    vectors++;
    if (r_done_cyc != LEN + 8) begin miscompares++; $display("FAIL bp_done_cycle got %0d want %0d", r_done_cyc, LEN + 8); end
    vectors++;
    if (r_data !== 20'(model(20))) begin miscompares++; $display("FAIL bp_data got %0d want %0d", r_data, model(20)); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL bp_done_width got %b want 0", done); end
  endtask

  task automatic test_abort;
    int extra;
    fill(3);
    out_ready = 1'b1;
    @(negedge clk); inner_start = 1'b1;
    @(negedge clk); inner_start = 1'b0;
    repeat (7) @(negedge clk);
    inner_rst = 1'b1;
    @(negedge clk); inner_rst = 1'b0;
    vectors++;
    if (rd_en !== 1'b0 || out_valid !== 1'b0 || rd_addr !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL abort_idle got en=%b vld=%b addr=%0d data=%0d want 0 0 0 0", rd_en, out_valid, rd_addr, out_data);
    end
    extra = 0;
    repeat (30) begin @(negedge clk); if (done || rd_en) extra++; end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL abort_no_done got %0d activity cycles want 0", extra); end
    // inner_rst held high, even alongside start, keeps the block idle
    inner_rst = 1'b1; inner_start = 1'b1;
    extra = 0;
    repeat (4) begin @(negedge clk); if (rd_en || out_valid || done) extra++; end
    inner_rst = 1'b0; inner_start = 1'b0;
    @(negedge clk);
    if (rd_en) extra++;
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL hold_inner_rst got %0d active cycles want 0", extra); end
    run_once(0, -1);
    vectors++;
    if (r_data !== 20'(model(20)) || r_done_cyc != LEN + 3) begin
      miscompares++;
      $display("FAIL abort_rerun got data=%0d done=%0d want %0d %0d", r_data, r_done_cyc, model(20), LEN + 3);
    end
  endtask

  task automatic test_ignore_start;
    int extra;
    fill(3);
    run_once(0, 5);
    extra = 0;
    repeat (25) begin @(negedge clk); if (done || rd_en) extra++; end
    vectors++;
    if (r_done_cyc != LEN + 3 || extra != 0) begin
      miscompares++;
      $display("FAIL ignore_start got done_cyc=%0d extra=%0d want %0d 0", r_done_cyc, extra, LEN + 3);
    end
    vectors++;
    if (r_data !== 20'(model(20)) || r_rd_cnt != LEN) begin
      miscompares++;
      $display("FAIL ignore_start_data got %0d reads=%0d want %0d %0d", r_data, r_rd_cnt, model(20), LEN);
    end
  endtask

  task automatic test_back_to_back;
    fill(3);
    run_once(0, -1);
    fill(3);
    run_once(0, -1);
    vectors++;
    if (r_done_cyc != LEN + 3 || r_rd_first != 1) begin
      miscompares++;
      $display("FAIL b2b_timing got done=%0d first_rd=%0d want %0d 1", r_done_cyc, r_rd_first, LEN + 3);
    end
    vectors++;
    if (r_data !== 20'(model(20))) begin miscompares++; $display("FAIL b2b_data got %0d want %0d", r_data, model(20)); end
  endtask

  task automatic test_async_reset;
    int  extra;
    bit  seen;
    fill(3);
    out_ready = 1'b0;
    seen = 0;
    @(negedge clk); inner_start = 1'b1;
    @(negedge clk); inner_start = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (out_valid) seen = 1; else @(negedge clk);
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL async_wait_valid got timeout want out_valid"); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || done !== 1'b0 || out_valid16 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst got vld=%b done=%b want 0 0", out_valid, done);
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (30) begin @(negedge clk); if (done || out_valid) extra++; end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL async_no_done got %0d active cycles want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_max();
    test_random();
    test_backpressure();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
